// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t : FSM encoding. ST_3 is never entered and decodes as IDLE.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_3    = 2'd3
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout = borrow out.
// Ports:
//   a, b, bin : input bits (minuend, subtrahend, borrow in)
//   d, bout   : difference bit, borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, Diff = A - B, one bit per clock, LSB first.
// Start/Busy/Done handshake: Busy is high for WIDTH cycles, then Done pulses
// for one cycle with Diff/Borrow/Overflow valid. Results hold until the next
// operation completes or reset.
// Ports:
//   Clk      : clock
//   Rst_n    : synchronous active-low reset (clears everything)
//   Start    : request, accepted in IDLE or DONE
//   A, B     : operands, latched on an accepted Start
//   Busy     : high in RUN
//   Done     : one-cycle result-valid pulse
//   Diff     : A - B modulo 2^WIDTH
//   Borrow   : unsigned underflow (A < B)
//   Overflow : signed two's-complement overflow
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             Overflow
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic             accept;
  logic             last_bit;

  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             a_msb, b_msb;
  logic             bflop;
  logic [CNT_W-1:0] cnt;

  logic             d_bit, bout_bit;

  // Signed overflow of a subtraction: operands of different sign and the
  // result sign differs from the minuend.
  function automatic logic sub_overflow(input logic am, input logic bm,
                                        input logic dm);
    return (am != bm) && (dm != am);
  endfunction

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (bflop),
    .d    (d_bit),
    .bout (bout_bit)
  );

  assign last_bit = (cnt == LAST_BIT);

  always_comb begin
    state_nxt = ST_IDLE;
    accept    = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      ST_RUN: begin
        Busy      = 1'b1;
        state_nxt = last_bit ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        Done = 1'b1;
        if (Start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      default: begin
        // ST_IDLE and the unused ST_3 behave identically
        if (Start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Serial datapath: operand shift, borrow chain, result assembly
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      bflop    <= 1'b0;
      cnt      <= '0;
      Diff     <= '0;
      Borrow   <= 1'b0;
      Overflow <= 1'b0;
    end else if (accept) begin
      a_sr   <= A;
      b_sr   <= B;
      a_msb  <= A[WIDTH-1];
      b_msb  <= B[WIDTH-1];
      bflop  <= 1'b0;
      cnt    <= '0;
    end else if (state == ST_RUN) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      res_sr <= {d_bit, res_sr[WIDTH-1:1]};
      bflop  <= bout_bit;
      cnt    <= cnt + CNT_W'(1);
      if (last_bit) begin
        // final bit lands at the MSB of the published result
        Diff     <= {d_bit, res_sr[WIDTH-1:1]};
        Borrow   <= bout_bit;
        Overflow <= sub_overflow(a_msb, b_msb, d_bit);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } exp_t;

  logic         Clk;
  logic         Rst_n;
  logic         Start;
  logic [W-1:0] A, B;
  logic         Busy, Done, Borrow, Overflow;
  logic [W-1:0] Diff;

  int errors;
  int checks;
  int pushes;
  int dones;
  exp_t exp_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Start    (Start),
    .A        (A),
    .B        (B),
    .Busy     (Busy),
    .Done     (Done),
    .Diff     (Diff),
    .Borrow   (Borrow),
    .Overflow (Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0] r;
    r = {1'b0, a} - {1'b0, b};
    e.diff   = r[W-1:0];
    e.borrow = r[W];
    e.ovf    = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    return e;
  endfunction

  // Scoreboard monitor: every Done must match the oldest pending expectation
  always @(negedge Clk) begin
    if (Done === 1'b1) begin
      dones++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Done with Diff=%0h, expected no Done", Diff);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("diff", 32'(Diff), 32'(e.diff));
        check("borrow", 32'(Borrow), 32'(e.borrow));
        check("overflow", 32'(Overflow), 32'(e.ovf));
      end
    end
  end

  // Issue one operation and follow the Busy/Done timing. When now=1 the
  // Start is driven in the current cycle (used for back-to-back from DONE).
  // When hold=1, Start stays high and A/B keep changing during RUN.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic hold, input logic now, input exp_t e);
    if (!now) @(negedge Clk);
    A = a;
    B = b;
    Start = 1'b1;
    exp_q.push_back(e);
    pushes++;
    @(negedge Clk);
    if (!hold) Start = 1'b0;
    for (int i = 0; i < W; i++) begin
      check("busy", 32'(Busy), 32'd1);
      if (hold) begin
        A = A + 4'd3;
        B = B ^ 4'hA;
        if (i == W - 1) Start = 1'b0;
      end
      @(negedge Clk);
    end
    check("busy_end", 32'(Busy), 32'd0);
    check("done_pulse", 32'(Done), 32'd1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    pushes = 0;
    dones  = 0;
    Rst_n  = 1'b0;
    Start  = 1'b0;
    A      = '0;
    B      = '0;
    repeat (2) @(negedge Clk);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_diff", 32'(Diff), 32'd0);
    check("rst_borrow", 32'(Borrow), 32'd0);
    check("rst_overflow", 32'(Overflow), 32'd0);
    Rst_n = 1'b1;

    // Directed vectors: {diff, borrow, ovf}
    issue(4'd7, 4'd3,  1'b0, 1'b0, '{4'd4,  1'b0, 1'b0});
    repeat (3) @(negedge Clk);
    check("hold_idle_diff", 32'(Diff), 32'd4);
    issue(4'd3, 4'd7,  1'b0, 1'b0, '{4'd12, 1'b1, 1'b0});
    issue(4'd8, 4'd1,  1'b0, 1'b0, '{4'd7,  1'b0, 1'b1});
    issue(4'd7, 4'd15, 1'b0, 1'b0, '{4'd8,  1'b1, 1'b1});

    // Start held and operands wiggled during RUN, then back-to-back from DONE
    issue(4'd5, 4'd5, 1'b1, 1'b0, '{4'd0, 1'b0, 1'b0});
    issue(4'd2, 4'd1, 1'b0, 1'b1, '{4'd1, 1'b0, 1'b0});

    // Reset at bit-cycle 2 of 9-4 aborts: no Done, all outputs cleared
    @(negedge Clk);
    A = 4'd9;
    B = 4'd4;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    check("abort_diff", 32'(Diff), 32'd0);
    check("abort_borrow", 32'(Borrow), 32'd0);
    check("abort_overflow", 32'(Overflow), 32'd0);
    repeat (8) @(negedge Clk);
    issue(4'd9, 4'd4, 1'b0, 1'b0, '{4'd5, 1'b0, 1'b1});

    // Exhaustive sweep against the arithmetic model
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue(4'(a), 4'(b), 1'b0, 1'b0, model(4'(a), 4'(b)));
      end
    end

    repeat (4) @(negedge Clk);
    check("pending_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(dones), 32'(pushes));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
